fp_mult: RTL

Sequential IEEE-754 floating-point multiplier. It is the responder side of the start/done multiply handshake issued by the FPU controller. The controller pulses start with operands; fp_mult runs an iterative shift-add significand multiply, normalises, rounds and packs the result, then pulses done. It sits beside the add/sub ALU in the float datapath.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_mult_if.sv | 36 +++
 rtl/fp_mant_mult.sv | 72 +++++++
 rtl/fp_mult.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point multiply path.
// Contents:
//   EXP_W / MANT_W / BIAS  default single-precision field widths and bias
//   signPos/expLsb         field-slice helpers for {sign, exp, frac} words
//   expAllOnes             all-ones exponent value used for both INF and QNAN
//   state_t                fp_mult controller state encoding (IDLE..DONE)
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    // Bit position of the sign in a {sign, exp, frac} word.
    function automatic int signPos(input int expW, input int mantW);
        return expW + mantW;
    endfunction

    // Lowest bit of the exponent field; the fraction sits below it.
    function automatic int expLsb(input int mantW);
        return mantW;
    endfunction

    // INF and QNAN both carry an all-ones exponent.
    function automatic int expAllOnes(input int expW);
        return (1 << expW) - 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/fp_mult_if.sv
// ---------------------------------------------------------------------------
// fp_mult_if
// Start/done multiply handshake between the FPU controller (master) and
// fp_mult (slave).
// Signals:
//   start   master->slave  request pulse, sampled only while the slave is idle
//   a, b    master->slave  operands {sign, exp, frac}, sampled with start
//   done    slave->master  one-cycle completion pulse
//   busy    slave->master  operation in flight (through the done cycle)
//   result  slave->master  product, held until the next accepted start
// ---------------------------------------------------------------------------
interface fp_mult_if #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W
);

    localparam int W = 1 + EXP_W + MANT_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         done;
    logic         busy;
    logic [W-1:0] result;

    modport master (
        output start, a, b,
        input  done, busy, result
    );

    modport slave (
        input  start, a, b,
        output done, busy, result
    );

endinterface

// File: rtl/fp_mant_mult.sv
// ---------------------------------------------------------------------------
// fp_mant_mult
// Iterative N-bit unsigned shift-add multiplier, one multiplier bit per cycle,
// LSB first. A go pulse loads the operands and clears the accumulator; the
// following N clock edges each perform one add-and-shift step.
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   go             load operands and start (restarts any run in progress)
//   multiplicand   N-bit operand added into the upper accumulator half
//   multiplier     N-bit operand consumed LSB first
//   ready          high once the last step has completed, until the next go
//   product        2N-bit accumulator; valid while ready is high
// ---------------------------------------------------------------------------
module fp_mant_mult #(
    parameter int N = fp_pkg::MANT_W + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           go,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           ready,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_count;
    logic           r_run;
    logic           r_ready;

    // The add happens on the upper half with one extra bit so the carry is
    // shifted down into the accumulator instead of being lost.
    logic [N:0]     w_sum;

    assign w_sum = {1'b0, r_acc[2*N-1:N]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

    // Load on go, otherwise step once per edge while running; the step with
    // count N-1 is the last one and raises ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_run    <= 1'b0;
            r_ready  <= 1'b0;
        end else if (go) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_count  <= '0;
            r_run    <= 1'b1;
            r_ready  <= 1'b0;
        end else if (r_run) begin
            r_acc    <= {w_sum, r_acc[N-1:1]};
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (r_count == CW'(N - 1)) begin
                r_run   <= 1'b0;
                r_ready <= 1'b1;
            end
        end
    end

    assign ready   = r_ready;
    assign product = r_acc;

endmodule

// File: rtl/fp_mult.sv
// ---------------------------------------------------------------------------
// fp_mult
// Sequential IEEE-754 multiplier, responder side of the FPU start/done
// multiply handshake. Flow: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE.
// Denormal inputs are flushed to zero, underflow flushes to signed zero and
// overflow saturates to signed infinity.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset, aborts any operation
//   bus     fp_mult_if.slave: start, a, b in; done, busy, result out
// Build option:
//   FP_MULT_ROUND_NEAREST_EN  defined: round-to-nearest-even;
//                             undefined: truncate (guard/sticky not built)
// Latency from the edge accepting start: normal results enter DONE
// MANT_W+4 edges later, special operands 2 edges later.
// ---------------------------------------------------------------------------
module fp_mult #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic     clock,
    input  logic     reset,
    fp_mult_if.slave bus
);

    import fp_pkg::*;

    localparam int W        = 1 + EXP_W + MANT_W;
    localparam int N        = MANT_W + 1;
    localparam int P_W      = 2 * N;
    localparam int E_W      = EXP_W + 2;
    localparam int SIGN_POS = signPos(EXP_W, MANT_W);
    localparam int EXP_LSB  = expLsb(MANT_W);

    localparam logic [EXP_W-1:0]      EXP_ONES = EXP_W'(expAllOnes(EXP_W));
    localparam logic signed [E_W-1:0] EXP_MAX  = E_W'(expAllOnes(EXP_W));
    localparam logic signed [E_W-1:0] BIAS_S   = E_W'(BIAS);

    state_t                  r_state;
    state_t                  w_nextState;

    logic [W-1:0]            r_a;
    logic [W-1:0]            r_b;
    logic [W-1:0]            r_result;
    logic                    r_sign;
    logic signed [E_W-1:0]   r_exp;
    logic [MANT_W-1:0]       r_frac;
    logic                    r_special;
    logic [W-1:0]            r_specialWord;

    logic [EXP_W-1:0]        w_expA;
    logic [EXP_W-1:0]        w_expB;
    logic [MANT_W-1:0]       w_fracA;
    logic [MANT_W-1:0]       w_fracB;
    logic                    w_zeroA;
    logic                    w_zeroB;
    logic                    w_specA;
    logic                    w_specB;
    logic                    w_nanA;
    logic                    w_nanB;
    logic                    w_infA;
    logic                    w_infB;
    logic                    w_sign;
    logic                    w_isNan;
    logic                    w_isInf;
    logic                    w_isZero;
    logic                    w_isSpecial;
    logic [W-1:0]            w_specialWord;
    logic signed [E_W-1:0]   w_expSum;

    logic                    w_mulGo;
    logic [N-1:0]            w_mcand;
    logic [N-1:0]            w_mplier;
    logic                    w_mulReady;
    logic [P_W-1:0]          w_product;

    logic [P_W-1:0]          w_shifted;
    logic [MANT_W-1:0]       w_normFrac;
    logic                    w_unusedTop;

    logic                    w_inc;
    logic [MANT_W:0]         w_fracSum;
    logic                    w_carry;
    logic signed [E_W-1:0]   w_roundExp;
    logic [MANT_W-1:0]       w_roundFrac;
    logic [W-1:0]            w_packed;

`ifdef FP_MULT_ROUND_NEAREST_EN
    logic                    r_guard;
    logic                    r_sticky;
    logic                    w_guard;
    logic                    w_sticky;
`else
    logic                    w_unusedLow;
`endif

    // ---------------- operand classification (used in UNPACK) ----------------
    assign w_expA  = r_a[EXP_LSB +: EXP_W];
    assign w_expB  = r_b[EXP_LSB +: EXP_W];
    assign w_fracA = r_a[MANT_W-1:0];
    assign w_fracB = r_b[MANT_W-1:0];

    // exp==0 covers both true zero and denormals, which are flushed.
    assign w_zeroA = (w_expA == '0);
    assign w_zeroB = (w_expB == '0);
    assign w_specA = (w_expA == EXP_ONES);
    assign w_specB = (w_expB == EXP_ONES);
    assign w_nanA  = w_specA && (w_fracA != '0);
    assign w_nanB  = w_specB && (w_fracB != '0);
    assign w_infA  = w_specA && (w_fracA == '0);
    assign w_infB  = w_specB && (w_fracB == '0);

    assign w_sign      = r_a[SIGN_POS] ^ r_b[SIGN_POS];
    assign w_isNan     = w_nanA || w_nanB || (w_infA && w_zeroB) || (w_infB && w_zeroA);
    assign w_isInf     = w_infA || w_infB;
    assign w_isZero    = w_zeroA || w_zeroB;
    assign w_isSpecial = w_specA || w_specB || w_isZero;
    assign w_expSum    = E_W'(w_expA) + E_W'(w_expB) - BIAS_S;

    // Priority NaN > INF > zero; the quiet NaN is always positive.
    always_comb begin
        w_specialWord = {w_sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        if (w_isNan) begin
            w_specialWord = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
        end else if (w_isInf) begin
            w_specialWord = {w_sign, EXP_ONES, {MANT_W{1'b0}}};
        end
    end

    // ---------------- significand multiplier ----------------
    // The multiplier is loaded on the same edge that accepts start, straight
    // from the bus, so its N steps overlap UNPACK and the first MULT cycles.
    // For special operands it simply runs unobserved.
    assign w_mulGo  = (r_state == IDLE) && bus.start;
    assign w_mcand  = {1'b1, bus.a[MANT_W-1:0]};
    assign w_mplier = {1'b1, bus.b[MANT_W-1:0]};

    fp_mant_mult #(
        .N (N)
    ) u_mantMult (
        .clock        (clock),
        .reset        (reset),
        .go           (w_mulGo),
        .multiplicand (w_mcand),
        .multiplier   (w_mplier),
        .ready        (w_mulReady),
        .product      (w_product)
    );

    // ---------------- normalisation ----------------
    // The product of two [1,2) significands is in [1,4); align it so the
    // leading one always sits at the top bit, then slice below it.
    assign w_shifted   = w_product[P_W-1] ? w_product : {w_product[P_W-2:0], 1'b0};
    assign w_normFrac  = w_shifted[P_W-2 -: MANT_W];
    assign w_unusedTop = w_shifted[P_W-1];

`ifdef FP_MULT_ROUND_NEAREST_EN
    assign w_guard  = w_shifted[N-1];
    assign w_sticky = |w_shifted[N-2:0];
    assign w_inc    = r_guard & (r_sticky | r_frac[0]);
`else
    assign w_unusedLow = ^w_shifted[N-1:0];
    assign w_inc       = 1'b0;
`endif

    // ---------------- rounding and packing ----------------
    assign w_fracSum   = {1'b0, r_frac} + {{MANT_W{1'b0}}, w_inc};
    assign w_carry     = w_fracSum[MANT_W];
    assign w_roundExp  = w_carry ? (r_exp + E_W'(1)) : r_exp;
    assign w_roundFrac = w_carry ? '0 : w_fracSum[MANT_W-1:0];

    // Range checks use the widened signed exponent so both overflow and
    // negative underflow are visible before truncating to EXP_W bits.
    always_comb begin
        w_packed = {r_sign, w_roundExp[EXP_W-1:0], w_roundFrac};
        if (w_roundExp >= EXP_MAX) begin
            w_packed = {r_sign, EXP_ONES, {MANT_W{1'b0}}};
        end else if (w_roundExp[E_W-1] || (w_roundExp == '0)) begin
            w_packed = {r_sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        end
    end

    // ---------------- controller ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Special operands bypass MULT/NORM but still pass through ROUND so the
    // result register is only ever written on the edge entering DONE.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_nextState = UNPACK;
            UNPACK:  w_nextState = w_isSpecial ? ROUND : MULT;
            MULT:    if (w_mulReady) w_nextState = NORM;
            NORM:    w_nextState = ROUND;
            ROUND:   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath registers, each written only in the state that owns it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_frac        <= '0;
            r_special     <= 1'b0;
            r_specialWord <= '0;
`ifdef FP_MULT_ROUND_NEAREST_EN
            r_guard       <= 1'b0;
            r_sticky      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a <= bus.a;
                        r_b <= bus.b;
                    end
                end
                UNPACK: begin
                    r_sign        <= w_sign;
                    r_exp         <= w_expSum;
                    r_special     <= w_isSpecial;
                    r_specialWord <= w_specialWord;
                end
                NORM: begin
                    r_frac <= w_normFrac;
                    r_exp  <= w_product[P_W-1] ? (r_exp + E_W'(1)) : r_exp;
`ifdef FP_MULT_ROUND_NEAREST_EN
                    r_guard  <= w_guard;
                    r_sticky <= w_sticky;
`endif
                end
                ROUND: begin
                    r_result <= r_special ? r_specialWord : w_packed;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done   = (r_state == DONE);
    assign bus.busy   = (r_state != IDLE);
    assign bus.result = r_result;

endmodule
